alu_exec_unit: RTL and testbench

- Parametrised successor to the combinational ALU-control decoder.
- Decodes ALUOp/funct into an operation code using the existing encoding, then executes on two DATA_W operands.
- Results are registered behind a valid/ready handshake.
- Adds an iterative multiply (MUL) and an illegal-funct error flag. Sits in the EX stage between the ID/EX and EX/MEM registers.

---
 rtl/alu_exec_unit.sv | 214 +++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU. Decodes ALUOp/funct into the legacy operation
// code, executes on two DATA_W operands and presents the result in an output
// register behind a valid/ready handshake. MUL is an iterative shift-add that
// takes DATA_W cycles; undecodable requests complete with illegal=1, result 0.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready is combinational)
//   alu_op, funct         controller ALUOp and instruction funct field
//   op_a, op_b            operands
//   out_valid / out_ready result handshake
//   result, zero          held result and its ==0 flag
//   operation, illegal    decoded op code / undecodable flag of the held result
module alu_exec_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter bit          MUL_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic [5:0]        operation,
  output logic              illegal
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] OP_ADD = 6'd27;
  localparam logic [5:0] OP_SUB = 6'd28;
  localparam logic [5:0] OP_SRL = 6'd29;
  localparam logic [5:0] OP_SLL = 6'd30;
  localparam logic [5:0] OP_XOR = 6'd31;
  localparam logic [5:0] OP_AND = 6'd32;
  localparam logic [5:0] OP_SLT = 6'd33;
  localparam logic [5:0] OP_MUL = 6'd34;

  logic [1:0]        r_state, w_nx_state;
  logic [CNT_W-1:0]  r_cnt, w_nx_cnt;
  logic [DATA_W-1:0] r_acc, w_nx_acc;
  logic [DATA_W-1:0] r_mcand, w_nx_mcand;
  logic [DATA_W-1:0] r_mplier, w_nx_mplier;
  logic              r_out_valid, w_nx_out_valid;
  logic [DATA_W-1:0] r_result, w_nx_result;
  logic              r_zero, w_nx_zero;
  logic [5:0]        r_operation, w_nx_operation;
  logic              r_illegal, w_nx_illegal;

  logic [5:0]         w_op;
  logic               w_illegal;
  logic [DATA_W-1:0]  w_exec;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_lt;
  logic               w_out_free;
  logic               w_accept;

  assign w_out_free = !r_out_valid || out_ready;
  assign in_ready   = (r_state == S_IDLE) && w_out_free;
  assign w_accept   = in_valid && in_ready;

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign operation = r_operation;
  assign illegal   = r_illegal;

  // ALUOp/funct decode into the legacy operation encoding
  always_comb begin
    w_op      = 6'd0;
    w_illegal = 1'b1;
    case (alu_op)
      3'b000: begin w_op = OP_ADD; w_illegal = 1'b0; end
      3'b001,
      3'b101: begin w_op = OP_SUB; w_illegal = 1'b0; end
      3'b010: begin
        case (funct)
          6'd21: begin w_op = OP_ADD; w_illegal = 1'b0; end
          6'd22: begin w_op = OP_SUB; w_illegal = 1'b0; end
          6'd23: begin w_op = OP_SRL; w_illegal = 1'b0; end
          6'd24: begin w_op = OP_SLL; w_illegal = 1'b0; end
          6'd25: begin w_op = OP_XOR; w_illegal = 1'b0; end
          6'd26: begin w_op = OP_AND; w_illegal = 1'b0; end
          6'd27: begin w_op = OP_SLT; w_illegal = 1'b0; end
          6'd28: begin
            if (MUL_EN) begin
              w_op      = OP_MUL;
              w_illegal = 1'b0;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Single-cycle datapath; MUL and illegal codes fall to zero here
  assign w_shamt = op_b[SHAMT_W-1:0];
  assign w_lt    = $signed(op_a) < $signed(op_b);

  always_comb begin
    w_exec = '0;
    case (w_op)
      OP_ADD:  w_exec = op_a + op_b;
      OP_SUB:  w_exec = op_a - op_b;
      OP_SRL:  w_exec = op_a >> w_shamt;
      OP_SLL:  w_exec = op_a << w_shamt;
      OP_XOR:  w_exec = op_a ^ op_b;
      OP_AND:  w_exec = op_a & op_b;
      OP_SLT:  w_exec = DATA_W'(w_lt);
      default: w_exec = '0;
    endcase
  end

  // Next-state and output-register update
  always_comb begin
    w_nx_state     = r_state;
    w_nx_cnt       = r_cnt;
    w_nx_acc       = r_acc;
    w_nx_mcand     = r_mcand;
    w_nx_mplier    = r_mplier;
    w_nx_out_valid = r_out_valid;
    w_nx_result    = r_result;
    w_nx_zero      = r_zero;
    w_nx_operation = r_operation;
    w_nx_illegal   = r_illegal;

    // Consumer took the held result; a load below may re-assert valid
    if (r_out_valid && out_ready) w_nx_out_valid = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_op == OP_MUL) begin
            w_nx_mcand  = op_a;
            w_nx_mplier = op_b;
            w_nx_acc    = '0;
            w_nx_cnt    = '0;
            w_nx_state  = S_MUL;
          end else begin
            w_nx_out_valid = 1'b1;
            w_nx_result    = w_exec;
            w_nx_zero      = (w_exec == '0);
            w_nx_operation = w_op;
            w_nx_illegal   = w_illegal;
          end
        end
      end
      S_MUL: begin
        // One multiplier bit per cycle; mcand drops overflow, keeping low bits
        if (r_mplier[0]) w_nx_acc = r_acc + r_mcand;
        w_nx_mcand  = r_mcand << 1;
        w_nx_mplier = r_mplier >> 1;
        if (r_cnt == CNT_W'(DATA_W - 1)) begin
          w_nx_cnt   = '0;
          w_nx_state = S_DONE;
        end else begin
          w_nx_cnt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        if (w_out_free) begin
          w_nx_out_valid = 1'b1;
          w_nx_result    = r_acc;
          w_nx_zero      = (r_acc == '0);
          w_nx_operation = OP_MUL;
          w_nx_illegal   = 1'b0;
          w_nx_state     = S_IDLE;
        end
      end
      default: w_nx_state = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_operation <= 6'd0;
      r_illegal   <= 1'b0;
    end else begin
      r_state     <= w_nx_state;
      r_cnt       <= w_nx_cnt;
      r_acc       <= w_nx_acc;
      r_mcand     <= w_nx_mcand;
      r_mplier    <= w_nx_mplier;
      r_out_valid <= w_nx_out_valid;
      r_result    <= w_nx_result;
      r_zero      <= w_nx_zero;
      r_operation <= w_nx_operation;
      r_illegal   <= w_nx_illegal;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_valid0;
  logic        in_ready, in_ready0;
  logic [2:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] op_a, op_b;
  logic        out_valid, out_valid0;
  logic        out_ready, out_ready0;
  logic [31:0] result, result0;
  logic        zero, zero0;
  logic [5:0]  operation, operation0;
  logic        illegal, illegal0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.DATA_W(32), .SHAMT_W(5), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .operation(operation), .illegal(illegal)
  );

  alu_exec_unit #(.DATA_W(32), .SHAMT_W(5), .MUL_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .alu_op(alu_op), .funct(funct), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid0), .out_ready(out_ready0), .result(result0),
    .zero(zero0), .operation(operation0), .illegal(illegal0)
  );

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [5:0]  opc;
    logic        ill;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    alu_op   = o;
    funct    = f;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int bad;
    int seen;
    logic [31:0] b2b_exp[3];

    vecs[0]  = '{3'b010, 6'd21, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 6'd27, 1'b0};
    vecs[1]  = '{3'b101, 6'd0,  32'd7,         32'd7,        32'h0000_0000, 6'd28, 1'b0};
    vecs[2]  = '{3'b010, 6'd24, 32'd1,         32'h25,       32'h0000_0020, 6'd30, 1'b0};
    vecs[3]  = '{3'b010, 6'd27, 32'hFFFF_FFFE, 32'd1,        32'h0000_0001, 6'd33, 1'b0};
    vecs[4]  = '{3'b010, 6'd27, 32'd1,         32'hFFFF_FFFE,32'h0000_0000, 6'd33, 1'b0};
    vecs[5]  = '{3'b010, 6'd23, 32'h8000_0000, 32'd31,       32'h0000_0001, 6'd29, 1'b0};
    vecs[6]  = '{3'b010, 6'd25, 32'hF0F0_F0F0, 32'h0FF0_0FF0,32'hFF00_FF00, 6'd31, 1'b0};
    vecs[7]  = '{3'b010, 6'd26, 32'hF0F0_F0F0, 32'h0FF0_0FF0,32'h00F0_00F0, 6'd32, 1'b0};
    vecs[8]  = '{3'b010, 6'd22, 32'd5,         32'd7,        32'hFFFF_FFFE, 6'd28, 1'b0};
    vecs[9]  = '{3'b000, 6'd0,  32'd3,         32'd4,        32'h0000_0007, 6'd27, 1'b0};
    vecs[10] = '{3'b001, 6'd0,  32'd9,         32'd9,        32'h0000_0000, 6'd28, 1'b0};
    vecs[11] = '{3'b010, 6'd40, 32'd12,        32'd34,       32'h0000_0000, 6'd0,  1'b1};
    vecs[12] = '{3'b011, 6'd21, 32'd12,        32'd34,       32'h0000_0000, 6'd0,  1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0;
    out_ready = 1'b1; out_ready0 = 1'b1;
    alu_op = 3'b000; funct = 6'd0; op_a = '0; op_b = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_operation", 32'(operation), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // MUL disabled: funct 28 is illegal and completes in one cycle
    @(negedge clk);
    alu_op = 3'b010; funct = 6'd28; op_a = 32'd3; op_b = 32'd4; in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    chk("nomul_valid", 32'(out_valid0), 32'd1);
    chk("nomul_illegal", 32'(illegal0), 32'd1);
    chk("nomul_operation", 32'(operation0), 32'd0);
    chk("nomul_result", result0, 32'd0);

    // Table-driven single ops
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_result", i), result, vecs[i].res);
      chk($sformatf("v%0d_operation", i), 32'(operation), 32'(vecs[i].opc));
      chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
      chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].res == 32'd0));
    end

    // Back-to-back ADDs at full throughput
    b2b_exp[0] = 32'd3; b2b_exp[1] = 32'd30; b2b_exp[2] = 32'd300;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("b2b%0d_valid", i - 1), 32'(out_valid), 32'd1);
        chk($sformatf("b2b%0d_result", i - 1), result, b2b_exp[i - 1]);
      end
      if (i < 3) begin
        drive(3'b010, 6'd21, 32'd1 * (10 ** i), 32'd2 * (10 ** i));
        chk($sformatf("b2b%0d_in_ready", i), 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: result held, second request waits
    drive(3'b010, 6'd21, 32'd5, 32'd6);
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_result", result, 32'd11);
    drive(3'b010, 6'd21, 32'd7, 32'd8);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d_result", i), result, 32'd11);
      chk($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_valid", 32'(out_valid), 32'd1);
    chk("bp_second_result", result, 32'd15);
    @(negedge clk);
    chk("bp_drain_valid", 32'(out_valid), 32'd0);

    // MUL latency and product
    drive(3'b010, 6'd28, 32'd1234, 32'd5678);
    chk("mul_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0; bad = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) bad++;
      @(negedge clk);
      lat++;
    end
    chk("mul_latency", 32'(lat), 32'd33);
    chk("mul_busy_ready", 32'(bad), 32'd0);
    chk("mul_result", result, 32'd7006652);
    chk("mul_operation", 32'(operation), 32'd34);
    chk("mul_illegal", 32'(illegal), 32'd0);

    // MUL completing into a stalled consumer
    drive(3'b010, 6'd28, 32'h0000_FFFF, 32'h0001_0001);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("mul2_latency", 32'(lat), 32'd33);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mul2_hold%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("mul2_hold%0d_result", i), result, 32'hFFFF_FFFF);
      chk($sformatf("mul2_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("mul2_release_valid", 32'(out_valid), 32'd0);
    chk("mul2_release_in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of a MUL
    drive(3'b010, 6'd28, 32'd3, 32'd5);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_zero", 32'(zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_valid_after", 32'(out_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_result", 32'(seen), 32'd0);

    // Unit still operational after reset
    drive(3'b010, 6'd21, 32'd40, 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_result", result, 32'd42);
    chk("post_rst_valid", 32'(out_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
